// File: rtl/sad_motion_search.sv
// rtl/sad_motion_search.sv - full-search SAD motion estimator sequencer
//
// Issues every candidate offset in a +/-RANGE window in raster order to an
// external 8x8 SAD core, tracks the returned SADs through a SAD_LATENCY-deep
// delay line and keeps the minimum (earliest candidate wins on ties).
//
// Ports:
//   clk        - clock, all logic on rising edge
//   aclr       - asynchronous active-high reset
//   start      - request a new search (ignored while busy and in DONE)
//   sad_in     - SAD from the core, SAD_LATENCY cycles after candidate issue
//   cand_valid - candidate offset being issued this cycle
//   cand_dx/dy - two's-complement candidate offset (0 when not issuing)
//   busy       - first issue cycle through last result cycle
//   done       - one-cycle completion pulse
//   best_sad   - minimum SAD of the last search
//   best_dx/dy - two's-complement offset of that minimum
module sad_motion_search #(
  parameter int RANGE       = 4,
  parameter int SAD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        start,
  input  logic [13:0] sad_in,
  output logic        cand_valid,
  output logic [4:0]  cand_dx,
  output logic [4:0]  cand_dy,
  output logic        busy,
  output logic        done,
  output logic [13:0] best_sad,
  output logic [4:0]  best_dx,
  output logic [4:0]  best_dy
);

  localparam logic [4:0] R_POS    = RANGE[4:0];
  localparam logic [4:0] R_NEG    = ~R_POS + 5'd1;
  localparam int         LAT_M1   = SAD_LATENCY - 1;
  localparam logic [3:0] LAT_LAST = LAT_M1[3:0];

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt_dx, cnt_dy;
  logic [3:0]  drain_cnt;
  logic        load;
  logic        first_pend;

  logic        dl_v  [SAD_LATENCY];
  logic [4:0]  dl_dx [SAD_LATENCY];
  logic [4:0]  dl_dy [SAD_LATENCY];
  logic        res_valid;

  assign load      = (state == IDLE) && start;
  assign res_valid = dl_v[SAD_LATENCY-1];

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cand_valid = 1'b0;
    cand_dx    = 5'd0;
    cand_dy    = 5'd0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SCAN;
      end
      SCAN: begin
        cand_valid = 1'b1;
        cand_dx    = cnt_dx;
        cand_dy    = cnt_dy;
        busy       = 1'b1;
        if (cnt_dx == R_POS && cnt_dy == R_POS) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == LAT_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Raster counters: dx inner, dy outer; drain counter restarts during SCAN
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      cnt_dx    <= 5'd0;
      cnt_dy    <= 5'd0;
      drain_cnt <= 4'd0;
    end else begin
      if (load) begin
        cnt_dx <= R_NEG;
        cnt_dy <= R_NEG;
      end else if (state == SCAN) begin
        if (cnt_dx == R_POS) begin
          cnt_dx <= R_NEG;
          cnt_dy <= cnt_dy + 5'd1;
        end else begin
          cnt_dx <= cnt_dx + 5'd1;
        end
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + 4'd1;
      else                drain_cnt <= 4'd0;
    end
  end

  // Delay line aligning each candidate's offset with its returning SAD
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < SAD_LATENCY; i++) begin
        dl_v[i]  <= 1'b0;
        dl_dx[i] <= 5'd0;
        dl_dy[i] <= 5'd0;
      end
    end else begin
      dl_v[0]  <= cand_valid;
      dl_dx[0] <= cand_dx;
      dl_dy[0] <= cand_dy;
      for (int i = 1; i < SAD_LATENCY; i++) begin
        dl_v[i]  <= dl_v[i-1];
        dl_dx[i] <= dl_dx[i-1];
        dl_dy[i] <= dl_dy[i-1];
      end
    end
  end

  // Best tracker: first result of a search loads unconditionally, later
  // results only on strictly smaller SAD so ties keep the earlier candidate
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      first_pend <= 1'b0;
      best_sad   <= 14'd0;
      best_dx    <= 5'd0;
      best_dy    <= 5'd0;
    end else begin
      if (load) begin
        first_pend <= 1'b1;
      end else if (res_valid) begin
        first_pend <= 1'b0;
      end
      if (res_valid && (first_pend || sad_in < best_sad)) begin
        best_sad <= sad_in;
        best_dx  <= dl_dx[SAD_LATENCY-1];
        best_dy  <= dl_dy[SAD_LATENCY-1];
      end
    end
  end

endmodule

// File: tb/tb_sad_motion_search.sv
// tb/tb_sad_motion_search.sv - scoreboard bench for sad_motion_search
module tb_sad_motion_search;

  typedef struct {
    logic [13:0] sad;
    logic [4:0]  dx;
    logic [4:0]  dy;
  } exp_t;

  logic        clk = 1'b0;
  logic        aclr = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic        start0, start1;
  logic [13:0] sad0, sad1;
  int          mode = 0;

  logic        cv0, busy0, done0, cv1, busy1, done1;
  logic [4:0]  cdx0, cdy0, bdx0, bdy0, cdx1, cdy1, bdx1, bdy1;
  logic [13:0] bs0, bs1;

  logic        m_cv, m_busy, m_done;
  logic [4:0]  m_cdx, m_cdy, m_bdx, m_bdy;
  logic [13:0] m_bs;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  exp_t        prev [2];
  exp_t        obs;

  always #5 clk = ~clk;

  assign start0 = sel ? 1'b0 : start;
  assign start1 = sel ? start : 1'b0;

  sad_motion_search #(.RANGE(4), .SAD_LATENCY(4)) dut (
    .clk(clk), .aclr(aclr), .start(start0), .sad_in(sad0),
    .cand_valid(cv0), .cand_dx(cdx0), .cand_dy(cdy0),
    .busy(busy0), .done(done0),
    .best_sad(bs0), .best_dx(bdx0), .best_dy(bdy0)
  );

  sad_motion_search #(.RANGE(1), .SAD_LATENCY(1)) dut1 (
    .clk(clk), .aclr(aclr), .start(start1), .sad_in(sad1),
    .cand_valid(cv1), .cand_dx(cdx1), .cand_dy(cdy1),
    .busy(busy1), .done(done1),
    .best_sad(bs1), .best_dx(bdx1), .best_dy(bdy1)
  );

  always_comb begin
    m_cv   = sel ? cv1   : cv0;
    m_cdx  = sel ? cdx1  : cdx0;
    m_cdy  = sel ? cdy1  : cdy0;
    m_busy = sel ? busy1 : busy0;
    m_done = sel ? done1 : done0;
    m_bs   = sel ? bs1   : bs0;
    m_bdx  = sel ? bdx1  : bdx0;
    m_bdy  = sel ? bdy1  : bdy0;
  end

  function automatic logic [13:0] sad_of(input int md, input int dx, input int dy, input int r);
    int idx;
    idx = (dy + r) * (2 * r + 1) + (dx + r);
    case (md)
      0:       sad_of = (dx == 2 && dy == -1) ? 14'd7 : 14'd100;
      1:       sad_of = ((dx == -3 && dy == 0) || (dx == 1 && dy == 3)) ? 14'd50 : 14'd200;
      2:       sad_of = 14'(16320 - idx);
      3:       sad_of = 14'(idx);
      default: sad_of = 14'((idx * 53 + 17) % 211 + 5);
    endcase
  endfunction

  // SAD core models: fixed latency, garbage 0 whenever nothing is in flight
  bit p0_v [4];
  int p0_dx[4], p0_dy[4];
  bit p1_v;
  int p1_dx, p1_dy;

  always @(posedge clk) begin
    p0_v[0]  <= cv0;
    p0_dx[0] <= int'($signed(cdx0));
    p0_dy[0] <= int'($signed(cdy0));
    for (int i = 1; i < 4; i++) begin
      p0_v[i]  <= p0_v[i-1];
      p0_dx[i] <= p0_dx[i-1];
      p0_dy[i] <= p0_dy[i-1];
    end
    p1_v  <= cv1;
    p1_dx <= int'($signed(cdx1));
    p1_dy <= int'($signed(cdy1));
  end

  always_comb begin
    sad0 = p0_v[3] ? sad_of(mode, p0_dx[3], p0_dy[3], 4) : 14'd0;
    sad1 = p1_v    ? sad_of(mode, p1_dx,    p1_dy,    1) : 14'd0;
  end

  // Runs one search on the selected DUT. Caller is at a falling edge; that
  // cycle is cycle 0. Start is re-pulsed in cycles sa/sb/sc; aclr is pulsed
  // in cycle abort_at (0 = never). Ends at the falling edge of cycle N+L+2.
  task automatic run_search(input int md, input int sa, input int sb, input int sc, input int abort_at);
    int r, l, n, w;
    int edx, edy;
    logic ev, eb, ed;
    exp_t e;
    bit first;
    logic [13:0] s;
    r = sel ? 1 : 4;
    l = sel ? 1 : 4;
    w = 2 * r + 1;
    n = w * w;
    mode = md;
    first = 1'b1;
    e.sad = 14'd0; e.dx = 5'd0; e.dy = 5'd0;
    for (int dy = -r; dy <= r; dy++) begin
      for (int dx = -r; dx <= r; dx++) begin
        s = sad_of(md, dx, dy, r);
        if (first || s < e.sad) begin
          e.sad = s; e.dx = 5'(dx); e.dy = 5'(dy);
          first = 1'b0;
        end
      end
    end
    exp_q.push_back(e);
    start = 1'b1;
    for (int k = 1; k <= n + l + 2; k++) begin
      @(negedge clk);
      start = (k == sa || k == sb || k == sc);
      if (k == abort_at) begin
        aclr = 1'b1;
        #1;
        checks++;
        if (m_cv !== 1'b0 || m_cdx !== 5'd0 || m_cdy !== 5'd0 || m_busy !== 1'b0 ||
            m_done !== 1'b0 || m_bs !== 14'd0 || m_bdx !== 5'd0 || m_bdy !== 5'd0) begin
          errors++;
          $display("FAIL abort_outputs: got cv=%b dx=%h dy=%h busy=%b done=%b bs=%0d bdx=%h bdy=%h, want all 0",
                   m_cv, m_cdx, m_cdy, m_busy, m_done, m_bs, m_bdx, m_bdy);
        end
        @(negedge clk);
        aclr = 1'b0;
        start = 1'b0;
        void'(exp_q.pop_front());
        prev[0].sad = 14'd0; prev[0].dx = 5'd0; prev[0].dy = 5'd0;
        prev[1] = prev[0];
        for (int j = 0; j < n + l + 4; j++) begin
          @(negedge clk);
          checks++;
          if (m_done !== 1'b0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: cycle %0d after release done=%b busy=%b, want 0 0", j, m_done, m_busy);
          end
        end
        return;
      end
      ev  = (k <= n);
      edx = ev ? ((k - 1) % w) - r : 0;
      edy = ev ? ((k - 1) / w) - r : 0;
      eb  = (k <= n + l);
      ed  = (k == n + l + 1);
      checks++;
      if (m_cv !== ev || m_cdx !== 5'(edx) || m_cdy !== 5'(edy)) begin
        errors++;
        $display("FAIL cand cycle %0d: got v=%b dx=%0d dy=%0d, want v=%b dx=%0d dy=%0d",
                 k, m_cv, $signed(m_cdx), $signed(m_cdy), ev, edx, edy);
      end
      checks++;
      if (m_busy !== eb || m_done !== ed) begin
        errors++;
        $display("FAIL busy_done cycle %0d: got busy=%b done=%b, want busy=%b done=%b", k, m_busy, m_done, eb, ed);
      end
      if (k <= l + 1) begin
        checks++;
        if (m_bs !== prev[sel].sad || m_bdx !== prev[sel].dx || m_bdy !== prev[sel].dy) begin
          errors++;
          $display("FAIL best_hold cycle %0d: got %0d (%0d,%0d), want %0d (%0d,%0d)", k,
                   m_bs, $signed(m_bdx), $signed(m_bdy), prev[sel].sad, $signed(prev[sel].dx), $signed(prev[sel].dy));
        end
      end
      if (k == l + 2) begin
        checks++;
        if (m_bs !== sad_of(md, -r, -r, r) || m_bdx !== 5'(-r) || m_bdy !== 5'(-r)) begin
          errors++;
          $display("FAIL first_result: got %0d (%0d,%0d), want %0d (%0d,%0d)",
                   m_bs, $signed(m_bdx), $signed(m_bdy), sad_of(md, -r, -r, r), -r, -r);
        end
      end
      if (k == n + l + 1) begin
        e = exp_q.pop_front();
        checks++;
        if (m_bs !== e.sad || m_bdx !== e.dx || m_bdy !== e.dy) begin
          errors++;
          $display("FAIL best_result: got %0d (%0d,%0d), want %0d (%0d,%0d)",
                   m_bs, $signed(m_bdx), $signed(m_bdy), e.sad, $signed(e.dx), $signed(e.dy));
        end
        prev[sel] = e;
        obs.sad = m_bs; obs.dx = m_bdx; obs.dy = m_bdy;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_obs(input string name, input int es, input int edx, input int edy);
    checks++;
    if (obs.sad !== 14'(es) || obs.dx !== 5'(edx) || obs.dy !== 5'(edy)) begin
      errors++;
      $display("FAIL %s: got %0d (%0d,%0d), want %0d (%0d,%0d)", name,
               obs.sad, $signed(obs.dx), $signed(obs.dy), es, edx, edy);
    end
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    #1;
    checks++;
    if ({cv0, cdx0, cdy0, busy0, done0, bs0, bdx0, bdy0} !== 41'd0 ||
        {cv1, cdx1, cdy1, busy1, done1, bs1, bdx1, bdy1} !== 41'd0) begin
      errors++;
      $display("FAIL reset_state: dut0 cv=%b busy=%b done=%b bs=%0d dut1 cv=%b busy=%b done=%b bs=%0d, want 0",
               cv0, busy0, done0, bs0, cv1, busy1, done1, bs1);
    end
    repeat (3) @(negedge clk);
    aclr = 1'b0;
    prev[0].sad = 14'd0; prev[0].dx = 5'd0; prev[0].dy = 5'd0;
    prev[1] = prev[0];
    @(negedge clk);
  endtask

  task automatic test_single_min();
    sel = 1'b0;
    run_search(0, -1, -1, -1, 0);
    check_obs("single_min", 7, 2, -1);
    @(negedge clk);
  endtask

  task automatic test_tie();
    run_search(1, -1, -1, -1, 0);
    check_obs("tie_earliest", 50, -3, 0);
    @(negedge clk);
  endtask

  task automatic test_ramps();
    run_search(2, -1, -1, -1, 0);
    check_obs("ramp_down", 16240, 4, 4);
    @(negedge clk);
    run_search(3, -1, -1, -1, 0);
    check_obs("ramp_up", 0, -4, -4);
    @(negedge clk);
  endtask

  // Starts during SCAN, DRAIN and DONE are ignored; a start in the cycle
  // right after done launches the next search immediately.
  task automatic test_back_to_back();
    run_search(0, 10, 85, 86, 0);
    check_obs("ignored_starts", 7, 2, -1);
    run_search(1, -1, -1, -1, 0);
    check_obs("back_to_back", 50, -3, 0);
    @(negedge clk);
  endtask

  task automatic test_abort();
    run_search(0, -1, -1, -1, 40);
    run_search(2, -1, -1, -1, 0);
    check_obs("after_abort", 16240, 4, 4);
    @(negedge clk);
  endtask

  task automatic test_small();
    sel = 1'b1;
    run_search(4, -1, -1, -1, 0);
    @(negedge clk);
    run_search(0, -1, -1, -1, 0);
    check_obs("small_min", 100, -1, -1);
    @(negedge clk);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_min();
    test_tie();
    test_ramps();
    test_back_to_back();
    test_abort();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
